// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding and
// requester port indices.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_e;

  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;

endpackage

// File: rtl/memory_arbiter_rr.sv
// Two-way round-robin selector: on contention the port not granted last wins.
module memory_arbiter_rr
  import memory_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic valid_o,
  output logic idx_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    idx_o   = FETCH;
    if (req0_i && req1_i) begin
      idx_o = (last_grant_i == FETCH) ? DATA : FETCH;
    end else if (req1_i) begin
      idx_o = DATA;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter granting a fetch and a data requester access to one memory.
// Optional ACCESS timeout with sticky error flag: define MEMORY_ARBITER_TIMEOUT_EN.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                     MEMORY_ARBITER_CLOCK_50,
  input  logic                     MEMORY_ARBITER_ResetInLow_In,
  input  logic                     MEMORY_ARBITER_REQ0_In,
  input  logic                     MEMORY_ARBITER_WR0_In,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_A0_InBus,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_B0_InBus,
  output logic                     MEMORY_ARBITER_ACK0_Out,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_Data0_OutBus,
  input  logic                     MEMORY_ARBITER_REQ1_In,
  input  logic                     MEMORY_ARBITER_WR1_In,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_A1_InBus,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_B1_InBus,
  output logic                     MEMORY_ARBITER_ACK1_Out,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_Data1_OutBus,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_MemA_OutBus,
  output logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_MemB_OutBus,
  output logic                     MEMORY_ARBITER_MemRD_Out,
  output logic                     MEMORY_ARBITER_MemWR_Out,
  input  logic                     MEMORY_ARBITER_MemACK_In,
  input  logic [DATAWIDTH_BUS-1:0] MEMORY_ARBITER_MemData_InBus,
  output logic                     MEMORY_ARBITER_Error_Out
);

  state_e                   state_q, state_d;
  logic [DATAWIDTH_BUS-1:0] addr_q, addr_d;
  logic [DATAWIDTH_BUS-1:0] wdata_q, wdata_d;
  logic                     wr_q, wr_d;
  logic                     grant_q, grant_d;
  logic [DATAWIDTH_BUS-1:0] data0_q, data0_d;
  logic [DATAWIDTH_BUS-1:0] data1_q, data1_d;
  logic                     rr_valid;
  logic                     rr_idx;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // grant_q doubles as the last-grant history feeding the round-robin selector
  memory_arbiter_rr u_rr (
    .req0_i       (MEMORY_ARBITER_REQ0_In),
    .req1_i       (MEMORY_ARBITER_REQ1_In),
    .last_grant_i (grant_q),
    .valid_o      (rr_valid),
    .idx_o        (rr_idx)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    grant_d = grant_q;
    data0_d = data0_q;
    data1_d = data1_q;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (rr_valid) begin
          grant_d = rr_idx;
          state_d = ACCESS;
          if (rr_idx == DATA) begin
            addr_d  = MEMORY_ARBITER_A1_InBus;
            wdata_d = MEMORY_ARBITER_B1_InBus;
            wr_d    = MEMORY_ARBITER_WR1_In;
          end else begin
            addr_d  = MEMORY_ARBITER_A0_InBus;
            wdata_d = MEMORY_ARBITER_B0_InBus;
            wr_d    = MEMORY_ARBITER_WR0_In;
          end
`ifdef MEMORY_ARBITER_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      ACCESS: begin
        if (MEMORY_ARBITER_MemACK_In) begin
          state_d = DONE;
          if (!wr_q) begin
            if (grant_q == DATA) data1_d = MEMORY_ARBITER_MemData_InBus;
            else                 data0_d = MEMORY_ARBITER_MemData_InBus;
          end
        end
`ifdef MEMORY_ARBITER_TIMEOUT_EN
        // Abandon the access on the last allowed cycle and hand back zero data
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (grant_q == DATA) data1_d = '0;
          else                 data0_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MEMORY_ARBITER_CLOCK_50 or negedge MEMORY_ARBITER_ResetInLow_In) begin
    if (!MEMORY_ARBITER_ResetInLow_In) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      grant_q <= DATA;
      data0_q <= '0;
      data1_q <= '0;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      grant_q <= grant_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Strobes and ACKs decode straight from state so reset clears them at once
  assign MEMORY_ARBITER_MemRD_Out    = (state_q == ACCESS) && !wr_q;
  assign MEMORY_ARBITER_MemWR_Out    = (state_q == ACCESS) &&  wr_q;
  assign MEMORY_ARBITER_ACK0_Out     = (state_q == DONE) && (grant_q == FETCH);
  assign MEMORY_ARBITER_ACK1_Out     = (state_q == DONE) && (grant_q == DATA);
  assign MEMORY_ARBITER_MemA_OutBus  = addr_q;
  assign MEMORY_ARBITER_MemB_OutBus  = wdata_q;
  assign MEMORY_ARBITER_Data0_OutBus = data0_q;
  assign MEMORY_ARBITER_Data1_OutBus = data1_q;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  assign MEMORY_ARBITER_Error_Out = err_q;
`else
  assign MEMORY_ARBITER_Error_Out = 1'b0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter (default 32-bit build).
module tb_memory_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0, wr0, req1, wr1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ack0, ack1;
  logic [W-1:0] data0, data1;
  logic [W-1:0] mem_a, mem_b;
  logic         mem_rd, mem_wr;
  logic         mem_ack;
  logic [W-1:0] mem_data;
  logic         err;

  int checks = 0;
  int errors = 0;

  memory_arbiter #(.DATAWIDTH_BUS(W), .TIMEOUT_CYCLES(16)) dut (
    .MEMORY_ARBITER_CLOCK_50      (clk),
    .MEMORY_ARBITER_ResetInLow_In (rst_n),
    .MEMORY_ARBITER_REQ0_In       (req0),
    .MEMORY_ARBITER_WR0_In        (wr0),
    .MEMORY_ARBITER_A0_InBus      (a0),
    .MEMORY_ARBITER_B0_InBus      (b0),
    .MEMORY_ARBITER_ACK0_Out      (ack0),
    .MEMORY_ARBITER_Data0_OutBus  (data0),
    .MEMORY_ARBITER_REQ1_In       (req1),
    .MEMORY_ARBITER_WR1_In        (wr1),
    .MEMORY_ARBITER_A1_InBus      (a1),
    .MEMORY_ARBITER_B1_InBus      (b1),
    .MEMORY_ARBITER_ACK1_Out      (ack1),
    .MEMORY_ARBITER_Data1_OutBus  (data1),
    .MEMORY_ARBITER_MemA_OutBus   (mem_a),
    .MEMORY_ARBITER_MemB_OutBus   (mem_b),
    .MEMORY_ARBITER_MemRD_Out     (mem_rd),
    .MEMORY_ARBITER_MemWR_Out     (mem_wr),
    .MEMORY_ARBITER_MemACK_In     (mem_ack),
    .MEMORY_ARBITER_MemData_InBus (mem_data),
    .MEMORY_ARBITER_Error_Out     (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  initial begin
    int exp_g [4];
    exp_g = '{0, 1, 0, 1};

    rst_n = 1'b0;
    req0 = 0; wr0 = 0; a0 = '0; b0 = '0;
    req1 = 0; wr1 = 0; a1 = '0; b1 = '0;
    mem_ack = 0; mem_data = '0;
    #12;
    chk("rst_rd",    mem_rd, 0);
    chk("rst_wr",    mem_wr, 0);
    chk("rst_ack0",  ack0, 0);
    chk("rst_ack1",  ack1, 0);
    chk("rst_err",   err, 0);
    chk("rst_data0", data0, 0);
    chk("rst_mema",  mem_a, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single read, MemACK tied high
    req0 = 1; wr0 = 0; a0 = 32'd5; mem_ack = 1; mem_data = 32'h8833FFFF;
    tick();
    chk("rd_memrd", mem_rd, 1);
    chk("rd_memwr", mem_wr, 0);
    chk("rd_mema",  mem_a, 32'd5);
    chk("rd_ack0_c1", ack0, 0);
    tick();
    chk("rd_ack0",  ack0, 1);
    chk("rd_ack1",  ack1, 0);
    chk("rd_data0", data0, 32'h8833FFFF);
    chk("rd_strobe_drop", mem_rd, 0);
    req0 = 0;
    tick();
    chk("rd_ack0_low", ack0, 0);
    chk("rd_data0_hold", data0, 32'h8833FFFF);

    // Write from port 1
    req1 = 1; wr1 = 1; a1 = 32'd3; b1 = 32'hDEADBEEF;
    tick();
    chk("wr_memwr", mem_wr, 1);
    chk("wr_memrd", mem_rd, 0);
    chk("wr_memb",  mem_b, 32'hDEADBEEF);
    chk("wr_mema",  mem_a, 32'd3);
    tick();
    chk("wr_ack1",  ack1, 1);
    chk("wr_ack0",  ack0, 0);
    chk("wr_memwr_drop", mem_wr, 0);
    chk("wr_data1_unchanged", data1, 0);
    req1 = 0; wr1 = 0;
    tick();
    chk("wr_memb_hold", mem_b, 32'hDEADBEEF);

    // Contention from reset: grants alternate starting with port 0
    rst_n = 1'b0;
    tick();
    a0 = 32'h10; a1 = 32'h20; mem_data = 32'h00000A0A;
    req0 = 1; req1 = 1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr_mema_%0d", i), mem_a, (exp_g[i] == 0) ? 32'h10 : 32'h20);
      tick();
      chk($sformatf("rr_ack0_%0d", i), ack0, (exp_g[i] == 0) ? 1 : 0);
      chk($sformatf("rr_ack1_%0d", i), ack1, (exp_g[i] == 1) ? 1 : 0);
      tick();
    end
    chk("rr_data0", data0, 32'h00000A0A);
    chk("rr_data1", data1, 32'h00000A0A);
    // An IDLE cycle with both requests high must not be counted as a grant above
    req0 = 0; req1 = 0;
    tick();
    tick();
    tick();

    // Wait states: MemACK low for four ACCESS cycles
    mem_ack = 0; req0 = 1; a0 = 32'd7;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ws_memrd_%0d", i), mem_rd, 1);
      chk($sformatf("ws_ack0_%0d", i), ack0, 0);
      tick();
    end
    mem_ack = 1; mem_data = 32'hCAFE0001;
    chk("ws_memrd_4", mem_rd, 1);
    tick();
    chk("ws_ack0", ack0, 1);
    chk("ws_data0", data0, 32'hCAFE0001);
    chk("ws_memrd_drop", mem_rd, 0);
    req0 = 0; mem_ack = 0;
    tick();
    chk("ws_ack0_once", ack0, 0);

    // Reset mid-access
    req1 = 1; wr1 = 1; a1 = 32'd9; b1 = 32'h55;
    tick();
    chk("mr_memwr_before", mem_wr, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_memwr_async", mem_wr, 0);
    chk("mr_memrd_async", mem_rd, 0);
    chk("mr_mema_async",  mem_a, 0);
    chk("mr_memb_async",  mem_b, 0);
    chk("mr_data0_async", data0, 0);
    req0 = 1; wr0 = 0; wr1 = 0; a0 = 32'h11; a1 = 32'h22;
    rst_n = 1'b1;
    tick();
    chk("mr_grant0_mema", mem_a, 32'h11);
    chk("mr_grant0_rd",   mem_rd, 1);
    mem_ack = 1; mem_data = 32'h12345678;
    tick();
    chk("mr_ack0", ack0, 1);
    chk("mr_ack1", ack1, 0);
    req0 = 0; req1 = 0; mem_ack = 0;
    tick();
    chk("mr_err", err, 0);

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    // MemACK stuck low: sixteen ACCESS cycles, then ACK with zero data
    req0 = 1; wr0 = 0; a0 = 32'h40; mem_data = 32'hFFFFFFFF;
    tick();
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("to_ack0_%0d", i), ack0, 0);
      tick();
    end
    chk("to_rd_last", mem_rd, 1);
    chk("to_err_before", err, 0);
    tick();
    chk("to_ack0", ack0, 1);
    chk("to_data0", data0, 0);
    chk("to_err", err, 1);
    req0 = 0;
    tick();
    tick();
    chk("to_err_sticky", err, 1);
    rst_n = 1'b0;
    #1;
    chk("to_err_reset", err, 0);
    rst_n = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 32: width of the address, write-data and read-data buses.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: maximum number of ACCESS-state cycles waiting for memory ACK; used only with MEMORY_ARBITER_TIMEOUT_EN.
REQ-003 MEMORY_ARBITER_CLOCK_50  in  1: the single clock; all state changes on its rising edge.
REQ-004 MEMORY_ARBITER_ResetInLow_In  in  1: reset, asynchronous, active-low.
REQ-005 MEMORY_ARBITER_REQ<n>_In  in  1 (n=0 fetch, n=1 data): access request; held high until ACK<n>.
REQ-006 MEMORY_ARBITER_WR<n>_In  in  1: 1 = write, 0 = read; sampled with REQ<n>.
REQ-007 MEMORY_ARBITER_A<n>_InBus  in  DATAWIDTH_BUS: requester address.
REQ-008 MEMORY_ARBITER_B<n>_InBus  in  DATAWIDTH_BUS: requester write data.
REQ-009 MEMORY_ARBITER_ACK<n>_Out  out  1: one-cycle completion pulse to requester n.
REQ-010 MEMORY_ARBITER_Data<n>_OutBus  out  DATAWIDTH_BUS: read data to requester n; valid while ACK<n> is high.
REQ-011 MEMORY_ARBITER_MemA_OutBus / MemB_OutBus  out  DATAWIDTH_BUS: address and write data to main memory.
REQ-012 MEMORY_ARBITER_MemRD_Out / MemWR_Out  out  1: read and write strobes to main memory.
REQ-013 MEMORY_ARBITER_MemACK_In  in  1; MEMORY_ARBITER_MemData_InBus  in  DATAWIDTH_BUS: memory acknowledge and read data.
REQ-014 MEMORY_ARBITER_Error_Out  out  1: sticky timeout flag.

Function
REQ-015 FSM has three states: IDLE, ACCESS, DONE.
REQ-016 IDLE: when any REQ<n> is high, the block registers the winner's A, B and WR plus the grant index, then goes to ACCESS; otherwise it stays in IDLE.
REQ-017 Arbitration is round-robin. When both REQs are high, the port not granted last wins; after reset, port 0 has priority.
REQ-018 ACCESS drives MemA/MemB from the registers. It asserts MemRD when WR=0 and MemWR when WR=1, never both.
REQ-019 ACCESS with MemACK_In=1: MemData_InBus is captured (reads only), strobes drop on the next cycle and the FSM goes to DONE.
REQ-020 DONE: ACK<grant>=1 for exactly one cycle and Data<grant> = captured word; the FSM returns to IDLE.
REQ-021 Latency with MemACK tied high: REQ seen in cycle 0, strobe in cycle 1, ACK in cycle 2. The same requester can be granted again, at the earliest, in cycle 3.
REQ-022 Only the granted port ever sees ACK. Data<n> holds its last captured value between accesses.
REQ-023 If REQ drops during ACCESS, the access still completes and the ACK pulse is still issued.
REQ-024 Strobes are low in IDLE and DONE. MemA/MemB hold their last value.

Reset
REQ-025 ResetInLow_In=0 immediately forces the following, including mid-access: FSM to IDLE, all strobes, ACKs and Error to 0, Data<n> and Mem buses to 0, last-grant to port 1 (so port 0 wins first).

Configuration
REQ-026 Macro MEMORY_ARBITER_TIMEOUT_EN defined: the block counts ACCESS cycles. When the count reaches TIMEOUT_CYCLES without MemACK, it sets Error_Out (sticky until reset), goes to DONE and returns all-zero data.
REQ-027 MEMORY_ARBITER_TIMEOUT_EN undefined: there is no counter, ACCESS waits for MemACK indefinitely and Error_Out is tied to 0.

Structure
REQ-028 The shared package holds the state encoding constants (IDLE=2'b00, ACCESS=2'b01, DONE=2'b10) and the port index constants FETCH=0, DATA=1.
REQ-029 The round-robin selector is a sub-module, memory_arbiter_rr, combinational: inputs are the two requests and last-grant; outputs are valid and index.

Verification
REQ-030 Single read: REQ0=1, WR0=0, A0=5, MemACK=1, MemData=0x8833FFFF in cycle 1. Expect MemRD=1 with MemA=5 in cycle 1, then ACK0=1 with Data0=0x8833FFFF in cycle 2.
REQ-031 Contention: REQ0 and REQ1 both high from reset. Expect grants in order 0,1,0,1, and ACK0 and ACK1 are never high in the same cycle.
REQ-032 Write: REQ1=1, WR1=1, A1=3, B1=0xDEADBEEF. Expect MemWR=1, MemRD=0, MemB=0xDEADBEEF in ACCESS, then ACK1=1.
REQ-033 Wait states: MemACK held low for 4 cycles. Expect the strobe held for 5 cycles and ACK exactly one cycle after MemACK.
REQ-034 Reset mid-access: reset pulsed low during ACCESS. Expect strobes at 0 without waiting for a clock edge, and after release, port 0 wins a simultaneous request.
REQ-035 With MEMORY_ARBITER_TIMEOUT_EN and MemACK stuck at 0: expect Error_Out=1 and ACK<n>=1 with Data=0 after 16 ACCESS cycles; Error_Out stays 1 until reset.
